surf_command_deframer: RTL

SURF_COMMAND_DEFRAMER -- requirements
Module: surf_command_deframer

---
 rtl/surf_cmd_pkg.sv | 35 +++
 rtl/surf_uart_rx.sv | 110 +++++++++++
 rtl/surf_command_deframer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/surf_cmd_pkg.sv
// surf_cmd_pkg
//   Shared definitions for the SURF command deframer:
//   - state_t    : deframer FSM state encoding
//   - rx_state_t : serial byte receiver state encoding
//   - DEF_TRIG_HEADER / DEF_CLEAR_HEADER : default header byte values
//   - CNT_W      : width of the saturating error counters
//   - sat_inc()  : saturating increment for the error counters
package surf_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BUF  = 3'd1,
        ST_ID   = 3'd2,
        ST_SUM  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] DEF_TRIG_HEADER  = 8'hA6;
    localparam logic [7:0] DEF_CLEAR_HEADER = 8'hA7;
    localparam int         CNT_W            = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/surf_uart_rx.sv
// surf_uart_rx
//   8N1 serial byte receiver, LSB first. The start edge is confirmed at
//   mid-bit; every following bit is sampled one bit period later, i.e. at
//   its centre. A low stop bit drops the byte and raises frame_err, after
//   which the receiver waits for the line to return high before looking
//   for another start bit.
// Ports:
//   clk33_i    in   system clock
//   rst_i      in   asynchronous active-high reset
//   rx         in   serial line, already synchronised to clk33_i
//   data       out  last received byte (stable while byte_valid is high)
//   byte_valid out  one-cycle strobe: data holds a good byte
//   frame_err  out  one-cycle strobe: byte dropped on a bad stop bit
module surf_uart_rx
    import surf_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk33_i,
    input  logic       rst_i,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        valid_n, ferr_n;

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!rx) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    // A glitch shorter than half a bit is not a start bit.
                    state_n = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    shreg_n   = {rx, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx) begin
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = shreg;

endmodule

// File: rtl/surf_command_deframer.sv
// surf_command_deframer
//   Decodes trigger and clear packets from the serial command line.
//   Trigger packet: TRIG_HEADER, buffer index, ID_BYTES of event ID (MSB
//   first), 8-bit additive checksum of the ID bytes. Clear packet: the single
//   byte CLEAR_HEADER.
// Ports:
//   clk33_i            in   system clock
//   rst_i              in   asynchronous active-high reset
//   cmd_i              in   asynchronous 8N1 serial line, idle high
//   cmd_debug_o        out  synchronised copy of cmd_i
//   digitize_o         out  one-hot one-cycle strobe for the addressed buffer
//   event_id_buffer_o  out  buffer index of the last completed packet
//   event_id_o         out  event ID of the last completed packet
//   event_id_ok_o      out  checksum match of the last completed packet
//   event_id_wr_o      out  one-cycle strobe: packet complete
//   clear_o            out  one-cycle strobe: clear command received
//   *_count_o          out  16-bit saturating error counters
module surf_command_deframer
    import surf_cmd_pkg::*;
#(
    parameter int         NUM_BUFFERS    = 4,
    parameter int         ID_BYTES       = 4,
    parameter int         CLKS_PER_BIT   = 16,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] TRIG_HEADER    = DEF_TRIG_HEADER,
    parameter logic [7:0] CLEAR_HEADER   = DEF_CLEAR_HEADER,
    localparam int        BUF_BITS       = $clog2(NUM_BUFFERS)
) (
    input  logic                    clk33_i,
    input  logic                    rst_i,
    input  logic                    cmd_i,
    output logic                    cmd_debug_o,
    output logic [NUM_BUFFERS-1:0]  digitize_o,
    output logic [BUF_BITS-1:0]     event_id_buffer_o,
    output logic [8*ID_BYTES-1:0]   event_id_o,
    output logic                    event_id_ok_o,
    output logic                    event_id_wr_o,
    output logic                    clear_o,
    output logic [CNT_W-1:0]        sum_err_count_o,
    output logic [CNT_W-1:0]        timeout_count_o,
    output logic [CNT_W-1:0]        frame_err_count_o,
    output logic [CNT_W-1:0]        bad_buf_count_o
);

    localparam int              ID_W     = 8 * ID_BYTES;
    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      ID_LAST  = 3'(ID_BYTES - 1);

    logic sync1, sync2;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours, just like the hardware.
    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= cmd_i;
            sync2 <= sync1;
        end
    end

    assign cmd_debug_o = sync2;

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr;

    surf_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk33_i    (clk33_i),
        .rst_i      (rst_i),
        .rx         (sync2),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    state_t              state, state_n;
    logic [TMR_W-1:0]    timer;
    logic [2:0]          byte_cnt;
    logic [7:0]          sum;
    logic [ID_W-1:0]     shadow;
    logic [BUF_BITS-1:0] buf_idx;

    logic in_packet, timed_out, buf_bad, id_last, sum_ok;

    assign in_packet = (state == ST_BUF) || (state == ST_ID) || (state == ST_SUM);
    assign timed_out = in_packet && !rx_valid && (timer == TMR_LAST);
    assign buf_bad   = (rx_data >> BUF_BITS) != 8'd0;
    assign id_last   = (byte_cnt == ID_LAST);
    assign sum_ok    = (sum == rx_data);

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (rx_valid && rx_data == TRIG_HEADER) state_n = ST_BUF;
            ST_BUF: begin
                if (timed_out)     state_n = ST_IDLE;
                else if (rx_valid) state_n = buf_bad ? ST_IDLE : ST_ID;
            end
            ST_ID: begin
                if (timed_out)                state_n = ST_IDLE;
                else if (rx_valid && id_last) state_n = ST_SUM;
            end
            ST_SUM: begin
                if (timed_out)     state_n = ST_IDLE;
                else if (rx_valid) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            timer             <= '0;
            byte_cnt          <= '0;
            sum               <= '0;
            shadow            <= '0;
            buf_idx           <= '0;
            digitize_o        <= '0;
            clear_o           <= 1'b0;
            event_id_wr_o     <= 1'b0;
            event_id_o        <= '0;
            event_id_buffer_o <= '0;
            event_id_ok_o     <= 1'b0;
            sum_err_count_o   <= '0;
            timeout_count_o   <= '0;
            frame_err_count_o <= '0;
            bad_buf_count_o   <= '0;
        end else begin
            digitize_o    <= '0;
            clear_o       <= 1'b0;
            event_id_wr_o <= 1'b0;

            // Inter-byte watchdog: runs only inside a packet, reloads on each byte.
            if (!in_packet || rx_valid) timer <= '0;
            else                        timer <= timer + 1'b1;

            if (timed_out) timeout_count_o   <= sat_inc(timeout_count_o);
            if (rx_ferr)   frame_err_count_o <= sat_inc(frame_err_count_o);

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == CLEAR_HEADER) clear_o <= 1'b1;
                    end
                    ST_BUF: begin
                        if (buf_bad) begin
                            bad_buf_count_o <= sat_inc(bad_buf_count_o);
                        end else begin
                            buf_idx    <= rx_data[BUF_BITS-1:0];
                            digitize_o <= NUM_BUFFERS'(1) << rx_data[BUF_BITS-1:0];
                            sum        <= '0;
                            byte_cnt   <= '0;
                        end
                    end
                    ST_ID: begin
                        shadow   <= (shadow << 8) | ID_W'(rx_data);
                        sum      <= sum + rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    ST_SUM: begin
                        // Results load on the edge into DONE, so they are
                        // already valid during the DONE cycle while
                        // event_id_wr_o is high, and hold until the next one.
                        event_id_o        <= shadow;
                        event_id_buffer_o <= buf_idx;
                        event_id_ok_o     <= sum_ok;
                        event_id_wr_o     <= 1'b1;
                        if (!sum_ok) sum_err_count_o <= sat_inc(sum_err_count_o);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
